simple_accumulator_cpu: RTL and testbench
=========================================

Name: simple_accumulator_cpu

Overview:
- Multi-cycle accumulator processor with a 12-bit instruction word, 8-bit instruction and data address spaces, and a 32-bit signed datapath.
- Sits between an external synchronous instruction ROM (256 x 12) and an external synchronous data RAM (256 x 32). It fetches from the ROM, reads and writes the RAM, and executes one instruction every 3 cycles until HALT.

Parameters:
- None. All widths are fixed: instruction 12, instruction address 8, data address 8, data 32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- instr  input  12  instruction from the ROM; valid one cycle after instr_addr is presented
- instr_addr  output  8  program counter, driven to the ROM
- mem_wr  output  1  data RAM write enable, sampled on the rising clk edge
- mem_addr  output  8  data RAM address
- mem_data_in  input  32 signed  read data from the RAM; valid one cycle after mem_addr is presented
- mem_data_out  output  32 signed  write data to the RAM; always equals ACC

Behaviour:
- External memory contract:
  - Both memories read synchronously with 1-cycle latency.
  - The RAM writes mem_data_out to mem_addr on the rising edge where mem_wr=1.
- State: PC[7:0], ACC[31:0] signed, IR[11:0], and a state register with states FETCH, DECODE, EXEC, HALT.
- Reset (rst=1 at a rising edge, from any state, including mid-instruction):
  - PC=0, ACC=0, IR=0, state=FETCH.
  - mem_wr is 0 combinationally while in FETCH.
- instr_addr = PC at all times.
- Instruction format: opcode = instr[11:8], operand = instr[7:0].
- FETCH:
  - The ROM registers instr for PC.
  - Next state is DECODE.
- DECODE:
  - instr is valid; IR <= instr.
  - mem_addr = instr[7:0].
  - mem_wr = 1 only if the opcode is STORE; the write therefore commits at the end of DECODE.
  - Next state is EXEC.
- EXEC:
  - mem_addr = IR[7:0]; mem_wr = 0.
  - mem_data_in holds mem[operand]. Update ACC and PC per the opcode table below.
  - Next state is FETCH, or HALT for the HALT opcode.
- HALT:
  - PC, ACC and IR are frozen; mem_wr = 0.
  - Only rst exits this state.
- Outside DECODE, mem_addr = IR[7:0].
- Opcodes (M = mem_data_in, k = operand; PC <= PC+1 unless a jump is taken):
  - 0 NOP: no change
  - 1 LOAD: ACC <= M
  - 2 STORE: write already done in DECODE; ACC unchanged
  - 3 ADD: ACC <= ACC+M
  - 4 SUB: ACC <= ACC-M
  - 5 AND: ACC <= ACC&M
  - 6 OR: ACC <= ACC|M
  - 7 XOR: ACC <= ACC^M
  - 8 LDI: ACC <= sign-extended k
  - 9 ADDI: ACC <= ACC + sign-extended k
  - A JMP: PC <= k
  - B JZ: PC <= k if ACC==0
  - C JN: PC <= k if ACC[31]==1
  - D SHL: ACC <= ACC << k[4:0]
  - E SAR: ACC <= ACC >>> k[4:0], arithmetic
  - F HALT: PC unchanged; next state HALT
- Arithmetic wraps modulo 2^32. There are no flags or overflow traps.
- PC increment wraps from 255 to 0.
- Jump conditions use ACC as it stands at EXEC, i.e. the result of the previous instruction.
- STORE followed by LOAD of the same address returns the new value, since the write commits 2 cycles before the next read.

Test Plan:
- Reset, then ROM = {LDI 5, ADDI -3, STORE 0x10, HALT} -> mem[0x10] = 2; mem_wr high for exactly one cycle (cycle 8 after reset release); instr_addr stays 3 after HALT.
- mem[0]=100, mem[1]=-30; ROM = {LOAD 0, SUB 1, STORE 2, HALT} -> mem[2] = 130.
- LDI 0x7F, SHL 24, ADDI 1 -> ACC = 0x7F000001; then SHL 1 -> 0xFE000002; then SAR 4 -> 0xFFE00000.
- Countdown loop LDI 3; L: ADDI -1; JZ end; JMP L; end: STORE 0x20; HALT -> mem[0x20] = 0; ADDI executed 3 times (instruction-count check).
- Program at PC 255 = NOP -> next fetch at PC 0.
- Assert rst during DECODE of a STORE (rst high at that edge) -> no write reaches the RAM; PC=0, ACC=0; execution restarts from address 0.

Source files
------------

// File: rtl/simple_accumulator_cpu.sv
// Multi-cycle accumulator processor: 12-bit instructions, 8-bit code and data
// addresses, 32-bit signed accumulator. Each instruction takes FETCH, DECODE
// and EXEC cycles against an external synchronous ROM and RAM (1-cycle reads).
module simple_accumulator_cpu (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        instr,
  output logic [7:0]         instr_addr,
  output logic               mem_wr,
  output logic [7:0]         mem_addr,
  input  logic signed [31:0] mem_data_in,
  output logic signed [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_ADDI  = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JN    = 4'hC;
  localparam logic [3:0] OP_SHL   = 4'hD;
  localparam logic [3:0] OP_SAR   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_pc;
  logic [7:0]         w_pc_next;
  logic signed [31:0] r_acc;
  logic signed [31:0] w_acc_next;
  logic [11:0]        r_ir;

  logic [3:0]         w_opcode;
  logic [7:0]         w_k;
  logic signed [31:0] w_k_sext;
  logic [7:0]         w_pc_inc;

  assign w_opcode     = r_ir[11:8];
  assign w_k          = r_ir[7:0];
  assign w_k_sext     = {{24{w_k[7]}}, w_k};
  assign w_pc_inc     = r_pc + 8'd1;
  assign instr_addr   = r_pc;
  assign mem_data_out = r_acc;

  // Next-state and memory-port control. The STORE write strobe is suppressed
  // while rst is high so a reset landing on DECODE never commits the write.
  always_comb begin
    w_state_next = r_state;
    mem_wr       = 1'b0;
    mem_addr     = r_ir[7:0];
    case (r_state)
      ST_FETCH: begin
        w_state_next = ST_DECODE;
      end
      ST_DECODE: begin
        mem_addr     = instr[7:0];
        mem_wr       = (instr[11:8] == OP_STORE) && !rst;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = (w_opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // Execute-stage result: new accumulator and program counter for the
  // instruction held in IR, using the RAM word read during DECODE.
  always_comb begin
    w_acc_next = r_acc;
    w_pc_next  = w_pc_inc;
    case (w_opcode)
      OP_NOP:   ;
      OP_LOAD:  w_acc_next = mem_data_in;
      OP_STORE: ;
      OP_ADD:   w_acc_next = r_acc + mem_data_in;
      OP_SUB:   w_acc_next = r_acc - mem_data_in;
      OP_AND:   w_acc_next = r_acc & mem_data_in;
      OP_OR:    w_acc_next = r_acc | mem_data_in;
      OP_XOR:   w_acc_next = r_acc ^ mem_data_in;
      OP_LDI:   w_acc_next = w_k_sext;
      OP_ADDI:  w_acc_next = r_acc + w_k_sext;
      OP_JMP:   w_pc_next  = w_k;
      OP_JZ:    w_pc_next  = (r_acc == 32'sd0) ? w_k : w_pc_inc;
      OP_JN:    w_pc_next  = r_acc[31] ? w_k : w_pc_inc;
      OP_SHL:   w_acc_next = r_acc << w_k[4:0];
      OP_SAR:   w_acc_next = r_acc >>> w_k[4:0];
      OP_HALT:  w_pc_next  = r_pc;
      default:  ;
    endcase
  end

  // Architectural state: IR captured in DECODE, ACC/PC committed in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= 8'd0;
      r_acc   <= 32'sd0;
      r_ir    <= 12'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_ir <= instr;
      end
      if (r_state == ST_EXEC) begin
        r_acc <= w_acc_next;
        r_pc  <= w_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_simple_accumulator_cpu.sv
// Bench for simple_accumulator_cpu: external ROM/RAM models, an
// instruction-level reference model that predicts the fetch-address trace and
// every RAM write, and a negedge monitor that checks them as they appear.
module tb_simple_accumulator_cpu;

  logic               clk;
  logic               rst;
  logic [11:0]        instr;
  logic [7:0]         instr_addr;
  logic               mem_wr;
  logic [7:0]         mem_addr;
  logic signed [31:0] mem_data_in;
  logic signed [31:0] mem_data_out;

  simple_accumulator_cpu dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_addr   (instr_addr),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memories
  logic [11:0] rom [256];
  logic [31:0] ram [256];
  logic [31:0] ram_init [256];
  logic        ram_load;

  always @(posedge clk) instr <= rom[instr_addr];

  always @(posedge clk) begin
    if (ram_load) begin
      ram <= ram_init;
    end else begin
      if (mem_wr) ram[mem_addr] <= mem_data_out;
      mem_data_in <= ram[mem_addr];
    end
  end

  // Scoreboard
  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0]  exp_pc_q [$];
  wr_t         exp_wr_q [$];
  logic [31:0] ref_ram [256];
  logic [7:0]  ref_pc;
  logic [31:0] ref_acc;
  int          ref_steps;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  int   mcyc = 0;
  int   fetch_hist [256];
  int   n_wr_seen;
  int   last_wr_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: fetch address every third cycle, and every RAM write strobe
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      mcyc = 0;
    end else begin
      mcyc++;
      if ((mcyc % 3 == 1) && exp_pc_q.size() > 0) begin
        logic [7:0] e;
        e = exp_pc_q.pop_front();
        fetch_hist[instr_addr]++;
        check($sformatf("fetch_pc@cyc%0d", mcyc), {24'd0, instr_addr}, {24'd0, e});
      end
      if (mem_wr) begin
        n_wr_seen++;
        last_wr_cyc = mcyc;
        if (exp_wr_q.size() == 0) begin
          check($sformatf("unexpected_write@cyc%0d", mcyc), 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("write_cycle", mcyc, w.cyc);
          check("write_addr", {24'd0, mem_addr}, {24'd0, w.addr});
          check("write_data", mem_data_out, w.data);
        end
      end
    end
  end

  // Instruction-level reference: runs the program from PC 0 until HALT,
  // recording the PC of every executed instruction and each store.
  task automatic model_run();
    logic [7:0]  pc;
    logic [31:0] acc;
    logic [11:0] ins;
    logic [3:0]  op;
    logic [7:0]  k;
    logic [31:0] m;
    logic [31:0] ks;
    bit          halted;
    pc = 8'd0; acc = 32'd0; halted = 0; ref_steps = 0;
    while (!halted && ref_steps < 1000) begin
      ins = rom[pc]; op = ins[11:8]; k = ins[7:0];
      m = ref_ram[k]; ks = {{24{k[7]}}, k};
      exp_pc_q.push_back(pc);
      case (op)
        4'h1: acc = m;
        4'h2: begin
          wr_t w;
          w.cyc = 3 * ref_steps + 2; w.addr = k; w.data = acc;
          exp_wr_q.push_back(w);
          ref_ram[k] = acc;
        end
        4'h3: acc = acc + m;
        4'h4: acc = acc - m;
        4'h5: acc = acc & m;
        4'h6: acc = acc | m;
        4'h7: acc = acc ^ m;
        4'h8: acc = ks;
        4'h9: acc = acc + ks;
        4'hD: acc = acc << k[4:0];
        4'hE: acc = $signed(acc) >>> k[4:0];
        default: ;
      endcase
      ref_steps++;
      if (op == 4'hF) halted = 1;
      else if (op == 4'hA) pc = k;
      else if (op == 4'hB && acc == 32'd0) pc = k;
      else if (op == 4'hC && acc[31]) pc = k;
      else if (!(op == 4'hB || op == 4'hC) || 1) pc = pc + 8'd1;
    end
    ref_pc = pc; ref_acc = acc;
  endtask

  // Jump ops must see ACC before this instruction; fix ordering above by
  // evaluating the branch before ACC-modifying ops (branches never modify ACC,
  // so the order in model_run is equivalent).

  task automatic run_program(input string tag);
    int mism;
    rst = 1'b1;
    mon_en = 1'b0;
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    ref_ram = ram_init;
    exp_pc_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 256; i++) fetch_hist[i] = 0;
    n_wr_seen = 0;
    last_wr_cyc = -1;
    model_run();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3 * ref_steps + 4) @(negedge clk);
    mon_en = 1'b0;
    check({tag, "_halt_pc"}, {24'd0, instr_addr}, {24'd0, ref_pc});
    check({tag, "_acc"}, mem_data_out, ref_acc);
    check({tag, "_pc_trace_left"}, exp_pc_q.size(), 0);
    check({tag, "_writes_left"}, exp_wr_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) mism++;
    check({tag, "_ram_words_wrong"}, mism, 0);
    $display("program %s: %0d instructions, %0d writes", tag, ref_steps, n_wr_seen);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 12'hF00;
      ram_init[i] = 32'd0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ram_load = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_pc", {24'd0, instr_addr}, 32'd0);
    check("reset_acc", mem_data_out, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);

    // LDI 5; ADDI -3; STORE 0x10; HALT
    clear_mem();
    rom[0] = 12'h805; rom[1] = 12'h9FD; rom[2] = 12'h210; rom[3] = 12'hF00;
    run_program("t1");
    check("t1_mem10", ram[8'h10], 32'd2);
    check("t1_write_count", n_wr_seen, 1);
    check("t1_write_cycle", last_wr_cyc, 8);
    check("t1_pc_after_halt", {24'd0, instr_addr}, 32'd3);

    // LOAD 0; SUB 1; STORE 2; HALT
    clear_mem();
    ram_init[0] = 32'd100; ram_init[1] = 32'hFFFF_FFE2;
    rom[0] = 12'h100; rom[1] = 12'h401; rom[2] = 12'h202; rom[3] = 12'hF00;
    run_program("t2");
    check("t2_mem2", ram[2], 32'd130);

    // Shifts
    clear_mem();
    rom[0] = 12'h87F; rom[1] = 12'hD18; rom[2] = 12'h901; rom[3] = 12'h200;
    rom[4] = 12'hD01; rom[5] = 12'h201; rom[6] = 12'hE04; rom[7] = 12'h202;
    rom[8] = 12'hF00;
    run_program("t3");
    check("t3_shl24_addi", ram[0], 32'h7F00_0001);
    check("t3_shl1", ram[1], 32'hFE00_0002);
    check("t3_sar4", ram[2], 32'hFFE0_0000);

    // Countdown loop
    clear_mem();
    ram_init[8'h20] = 32'h0000_DEAD;
    rom[0] = 12'h803; rom[1] = 12'h9FF; rom[2] = 12'hB04; rom[3] = 12'hA01;
    rom[4] = 12'h220; rom[5] = 12'hF00;
    run_program("t4");
    check("t4_mem20", ram[8'h20], 32'd0);
    check("t4_addi_count", fetch_hist[1], 3);

    // PC wrap 255 -> 0
    clear_mem();
    rom[0] = 12'hC05; rom[1] = 12'h8FF; rom[2] = 12'hAFF; rom[255] = 12'h000;
    rom[5] = 12'h240; rom[6] = 12'hF00;
    run_program("t5");
    check("t5_fetch255", fetch_hist[255], 1);
    check("t5_fetch0_twice", fetch_hist[0], 2);
    check("t5_mem40", ram[8'h40], 32'hFFFF_FFFF);

    // Reset during DECODE of a STORE
    clear_mem();
    ram_init[8'h30] = 32'h55;
    rom[0] = 12'h809; rom[1] = 12'h230; rom[2] = 12'hF00;
    mon_en = 1'b0;
    rst = 1'b1; ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("t6_store_decoding", {31'd0, mem_wr}, 32'd1);
    check("t6_store_addr", {24'd0, mem_addr}, 32'h30);
    rst = 1'b1;
    #1;
    check("t6_mem_wr_gated", {31'd0, mem_wr}, 32'd0);
    @(posedge clk); #1;
    check("t6_no_write", ram[8'h30], 32'h55);
    check("t6_pc_reset", {24'd0, instr_addr}, 32'd0);
    check("t6_acc_reset", mem_data_out, 32'd0);
    rst = 1'b0;
    repeat (9) @(posedge clk); #1;
    check("t6_restart_write", ram[8'h30], 32'd9);
    check("t6_restart_halt_pc", {24'd0, instr_addr}, 32'd2);

    // Random forward-branching programs
    for (int p = 0; p < 6; p++) begin
      int n;
      n = 40;
      clear_mem();
      for (int i = 0; i < 16; i++) ram_init[i] = $urandom;
      for (int pc = 0; pc < n; pc++) begin
        logic [3:0] op;
        logic [7:0] k;
        op = 4'($urandom_range(0, 14));
        if (op >= 4'h1 && op <= 4'h7) k = 8'($urandom_range(0, 15));
        else if (op >= 4'hA && op <= 4'hC) k = 8'($urandom_range(pc + 1, n));
        else k = 8'($urandom);
        rom[pc] = {op, k};
      end
      run_program($sformatf("rand%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
